cp0_exc_unit: RTL and testbench

Parametrised coprocessor-0 exception/interrupt unit for the pipelined MIPS core, sitting beside the M stage. It merges the per-instruction exception code produced by decode/ALU/DM checks with `HW_INT` external interrupt lines and an internal Count/Compare timer. It also holds SR, Cause and EPC, and issues a single-cycle-decided exception request to the NPC and pipeline flush logic. It supersedes the fixed-priority combinational ExcCode generation with a stateful, maskable, multi-source controller.

---
 rtl/cp0_exc_unit.sv | 176 +++++++++++++++++
 tb/tb_cp0_exc_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cp0_exc_unit                                                  |
// | Purpose  : Coprocessor-0 exception/interrupt controller beside the M     |
// |            stage. Merges the M-stage exception code with external        |
// |            interrupt lines and a Count/Compare timer, holds SR, Cause    |
// |            and EPC, and raises a same-cycle exception request.           |
// | Ports    : clk, reset (async, active-low)                                |
// |            pc_i, bd_i, exc_code_i   - M-stage instruction context        |
// |            hw_int_i                 - external interrupt levels          |
// |            we_i, addr_i, wdata_i    - mtc0 write port                    |
// |            eret_i                   - eret in M stage                    |
// |            rdata_o                  - mfc0 read data (comb. on addr_i)   |
// |            req_o                    - take exception/interrupt now       |
// |            epc_o, handler_pc_o      - eret target / handler entry        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module cp0_exc_unit #(
    parameter int          HW_INT   = 5,
    parameter logic [31:0] EXC_BASE = 32'h0000_4180,
    parameter logic [31:0] PRID     = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc_i,
    input  logic              bd_i,
    input  logic [4:0]        exc_code_i,
    input  logic [HW_INT-1:0] hw_int_i,
    input  logic              we_i,
    input  logic [4:0]        addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              eret_i,
    output logic [31:0]       rdata_o,
    output logic              req_o,
    output logic [31:0]       epc_o,
    output logic [31:0]       handler_pc_o
);

    // Pending/mask field width: external lines plus the timer bit on top.
    localparam int NIP = HW_INT + 1;

    localparam logic [4:0] c_ADDR_COUNT   = 5'd9;
    localparam logic [4:0] c_ADDR_COMPARE = 5'd11;
    localparam logic [4:0] c_ADDR_SR      = 5'd12;
    localparam logic [4:0] c_ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] c_ADDR_EPC     = 5'd14;
    localparam logic [4:0] c_ADDR_PRID    = 5'd15;

    logic [31:0]       r_count;
    logic [31:0]       r_compare;
    logic [NIP-1:0]    r_im;
    logic              r_exl;
    logic              r_ie;
    logic              r_bd;
    logic [HW_INT-1:0] r_ip_hw;
    logic              r_ip_tmr;
    logic [4:0]        r_exc_code;
    logic [31:0]       r_epc;

    logic [NIP-1:0]    w_ip;
    logic              w_int_req;
    logic              w_exc_req;
    logic              w_req;
    logic              w_wr;
    logic              w_tmr_match;
    logic [31:0]       w_pc_sel;
    logic [31:0]       w_epc_next;
    logic [31:0]       w_sr;
    logic [31:0]       w_cause;

    assign w_ip      = {r_ip_tmr, r_ip_hw};
    assign w_int_req = r_ie & ~r_exl & (|(w_ip & r_im));
    assign w_exc_req = (exc_code_i != 5'd0) & ~r_exl;
    // eret suppresses any request so the return always completes first.
    assign w_req     = (w_int_req | w_exc_req) & ~eret_i;
    // A taken exception wins over an mtc0 in the same cycle.
    assign w_wr      = we_i & ~w_req;

    assign w_tmr_match = (r_compare != 32'd0) && (r_count == r_compare);

    // Delay-slot faults restart at the branch, one word earlier.
    assign w_pc_sel   = bd_i ? (pc_i - 32'd4) : pc_i;
    assign w_epc_next = w_pc_sel & 32'hFFFF_FFFC;

    assign req_o        = w_req;
    assign epc_o        = r_epc;
    assign handler_pc_o = EXC_BASE;

    // Count: free-running, an mtc0 write replaces that cycle's increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 32'd0;
        end else if (w_wr && (addr_i == c_ADDR_COUNT)) begin
            r_count <= wdata_i;
        end else begin
            r_count <= r_count + 32'd1;
        end
    end

    // Compare and the sticky timer pending bit. A Compare write always
    // leaves the pending bit clear, even if a match happens that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_compare <= 32'd0;
            r_ip_tmr  <= 1'b0;
        end else if (w_wr && (addr_i == c_ADDR_COMPARE)) begin
            r_compare <= wdata_i;
            r_ip_tmr  <= 1'b0;
        end else if (w_tmr_match) begin
            r_ip_tmr  <= 1'b1;
        end
    end

    // External lines: one-cycle synchroniser, level sensitive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ip_hw <= '0;
        end else begin
            r_ip_hw <= hw_int_i;
        end
    end

    // SR / Cause / EPC. EXL is the only mode state: 0 = normal, 1 = handler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_exc_code <= 5'd0;
            r_epc      <= 32'd0;
        end else if (w_req) begin
            r_exl      <= 1'b1;
            r_bd       <= bd_i;
            r_epc      <= w_epc_next;
            r_exc_code <= w_int_req ? 5'd0 : exc_code_i;
        end else begin
            if (eret_i) begin
                r_exl <= 1'b0;
            end
            if (w_wr && (addr_i == c_ADDR_SR)) begin
                r_im  <= wdata_i[10 +: NIP];
                r_exl <= wdata_i[1];
                r_ie  <= wdata_i[0];
            end
            if (w_wr && (addr_i == c_ADDR_EPC)) begin
                r_epc <= wdata_i & 32'hFFFF_FFFC;
            end
        end
    end

    always_comb begin
        w_sr              = 32'd0;
        w_sr[10 +: NIP]   = r_im;
        w_sr[1]           = r_exl;
        w_sr[0]           = r_ie;

        w_cause           = 32'd0;
        w_cause[31]       = r_bd;
        w_cause[10 +: NIP] = w_ip;
        w_cause[6:2]      = r_exc_code;

        rdata_o = 32'd0;
        case (addr_i)
            c_ADDR_COUNT:   rdata_o = r_count;
            c_ADDR_COMPARE: rdata_o = r_compare;
            c_ADDR_SR:      rdata_o = w_sr;
            c_ADDR_CAUSE:   rdata_o = w_cause;
            c_ADDR_EPC:     rdata_o = r_epc;
            c_ADDR_PRID:    rdata_o = PRID;
            default:        rdata_o = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cp0_exc_unit                                               |
// | Purpose  : Self-checking bench for cp0_exc_unit: directed scenarios plus |
// |            randomized traffic against a register-level reference model. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_cp0_exc_unit;

    localparam int          HW_INT   = 5;
    localparam logic [31:0] EXC_BASE = 32'h0000_4180;
    localparam logic [31:0] PRID     = 32'h0000_0001;

    localparam logic [31:0] c_IPM       = (32'd1 << (HW_INT + 1)) - 32'd1;
    localparam logic [31:0] c_SR_MASK   = (c_IPM << 10) | 32'd3;
    localparam logic [31:0] c_IP_FIELD  = c_IPM << 10;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [31:0]       pc_i = '0;
    logic              bd_i = 1'b0;
    logic [4:0]        exc_code_i = '0;
    logic [HW_INT-1:0] hw_int_i = '0;
    logic              we_i = 1'b0;
    logic [4:0]        addr_i = '0;
    logic [31:0]       wdata_i = '0;
    logic              eret_i = 1'b0;
    logic [31:0]       rdata_o;
    logic              req_o;
    logic [31:0]       epc_o;
    logic [31:0]       handler_pc_o;

    cp0_exc_unit #(.HW_INT(HW_INT), .EXC_BASE(EXC_BASE), .PRID(PRID)) dut (
        .clk(clk), .reset(reset), .pc_i(pc_i), .bd_i(bd_i),
        .exc_code_i(exc_code_i), .hw_int_i(hw_int_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .eret_i(eret_i),
        .rdata_o(rdata_o), .req_o(req_o), .epc_o(epc_o),
        .handler_pc_o(handler_pc_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: architectural register images, full 32-bit words.
    logic [31:0] m_count, m_compare, m_sr, m_cause, m_epc;

    function automatic logic exp_int();
        logic [31:0] ip, im;
        ip = (m_cause >> 10) & c_IPM;
        im = (m_sr >> 10) & c_IPM;
        return m_sr[0] && !m_sr[1] && ((ip & im) != 32'd0);
    endfunction

    function automatic logic exp_req();
        return (exp_int() || ((exc_code_i != 5'd0) && !m_sr[1])) && !eret_i;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_count = 0; m_compare = 0; m_sr = 0; m_cause = 0; m_epc = 0;
    endtask

    // Advance the model across one rising edge using the inputs in force.
    task automatic model_edge();
        logic        take, intr, wr, tbit;
        logic [31:0] ip, src;
        intr = exp_int();
        take = exp_req();
        wr   = we_i && !take;
        ip   = (m_cause >> 10) & c_IPM;
        tbit = ip[HW_INT];
        if ((m_compare != 0) && (m_count == m_compare)) tbit = 1'b1;
        if (wr && addr_i == 5'd11) begin
            m_compare = wdata_i;
            tbit = 1'b0;
        end
        ip = 32'(hw_int_i) | (32'(tbit) << HW_INT);
        m_cause = (m_cause & ~c_IP_FIELD) | (ip << 10);
        if (take) begin
            m_sr         = m_sr | 32'd2;
            m_cause[31]  = bd_i;
            m_cause[6:2] = intr ? 5'd0 : exc_code_i;
            src          = bd_i ? pc_i - 32'd4 : pc_i;
            m_epc        = src & ~32'd3;
        end else begin
            if (eret_i) m_sr = m_sr & ~32'd2;
            if (wr && addr_i == 5'd12) m_sr  = wdata_i & c_SR_MASK;
            if (wr && addr_i == 5'd14) m_epc = wdata_i & ~32'd3;
        end
        m_count = (wr && addr_i == 5'd9) ? wdata_i : m_count + 32'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        addr_i = 5'd15;
        #2;
        n_cmp++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b want 0", req_o); end
        n_cmp++; if (epc_o !== 32'd0) begin n_fail++; $display("FAIL rst_epc: got %h want 0", epc_o); end
        n_cmp++; if (rdata_o !== PRID) begin n_fail++; $display("FAIL rst_prid: got %h want %h", rdata_o, PRID); end
        n_cmp++; if (handler_pc_o !== EXC_BASE) begin n_fail++; $display("FAIL rst_handler: got %h want %h", handler_pc_o, EXC_BASE); end
        addr_i = 5'd12; #1;
        n_cmp++; if (rdata_o !== 32'd0) begin n_fail++; $display("FAIL rst_sr: got %h want 0", rdata_o); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_overflow();
        pc_i = 32'h3010; exc_code_i = 5'd12; bd_i = 1'b0; addr_i = 5'd13;
        @(negedge clk);
        n_cmp++; if (req_o !== 1'b1) begin n_fail++; $display("FAIL ovf_req: got %0b want 1", req_o); end
        tick();
        @(negedge clk);
        n_cmp++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL ovf_masked: got %0b want 0", req_o); end
        n_cmp++; if (epc_o !== 32'h3010) begin n_fail++; $display("FAIL ovf_epc: got %h want 3010", epc_o); end
        n_cmp++; if (rdata_o[6:2] !== 5'd12) begin n_fail++; $display("FAIL ovf_code: got %0d want 12", rdata_o[6:2]); end
        addr_i = 5'd12; #1;
        n_cmp++; if (rdata_o[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_exl: got %0b want 1", rdata_o[1]); end
        tick();
    endtask

    task automatic test_delay_slot();
        exc_code_i = 5'd0; eret_i = 1'b1;
        tick();
        eret_i = 1'b0; bd_i = 1'b1; pc_i = 32'h3024; exc_code_i = 5'd4;
        @(negedge clk);
        n_cmp++; if (req_o !== 1'b1) begin n_fail++; $display("FAIL ds_req: got %0b want 1", req_o); end
        tick();
        exc_code_i = 5'd0; bd_i = 1'b0; addr_i = 5'd13;
        @(negedge clk);
        n_cmp++; if (epc_o !== 32'h3020) begin n_fail++; $display("FAIL ds_epc: got %h want 3020", epc_o); end
        n_cmp++; if (rdata_o[31] !== 1'b1) begin n_fail++; $display("FAIL ds_bd: got %0b want 1", rdata_o[31]); end
        n_cmp++; if (rdata_o[6:2] !== 5'd4) begin n_fail++; $display("FAIL ds_code: got %0d want 4", rdata_o[6:2]); end
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0; addr_i = 5'd12;
        @(negedge clk);
        n_cmp++; if (rdata_o[1] !== 1'b0) begin n_fail++; $display("FAIL eret_exl: got %0b want 0", rdata_o[1]); end
        n_cmp++; if (epc_o !== 32'h3020) begin n_fail++; $display("FAIL eret_epc: got %h want 3020", epc_o); end
        tick();
    endtask

    task automatic test_priority();
        we_i = 1'b1; addr_i = 5'd12; wdata_i = 32'h0000_0401;
        tick();
        we_i = 1'b0; hw_int_i = 5'b00001; addr_i = 5'd13;
        @(negedge clk);
        n_cmp++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL int_sync: got %0b want 0", req_o); end
        tick();
        exc_code_i = 5'd10;
        @(negedge clk);
        n_cmp++; if (req_o !== 1'b1) begin n_fail++; $display("FAIL int_req: got %0b want 1", req_o); end
        tick();
        exc_code_i = 5'd0; hw_int_i = '0; eret_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (rdata_o[6:2] !== 5'd0) begin n_fail++; $display("FAIL prio_code: got %0d want 0", rdata_o[6:2]); end
        n_cmp++; if (rdata_o[10] !== 1'b1) begin n_fail++; $display("FAIL prio_ip0: got %0b want 1", rdata_o[10]); end
        tick();
        eret_i = 1'b0;
    endtask

    task automatic test_timer();
        we_i = 1'b1; addr_i = 5'd9; wdata_i = 32'd1000;
        tick();
        addr_i = 5'd11; wdata_i = 32'd20;
        tick();
        addr_i = 5'd12; wdata_i = (32'd1 << (10 + HW_INT)) | 32'd1;
        tick();
        addr_i = 5'd9; wdata_i = 32'd0;
        tick();
        we_i = 1'b0; addr_i = 5'd13;
        repeat (20) tick();
        @(negedge clk);
        n_cmp++; if (rdata_o[10+HW_INT] !== 1'b0) begin n_fail++; $display("FAIL tmr_early: got %0b want 0", rdata_o[10+HW_INT]); end
        n_cmp++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL tmr_req_early: got %0b want 0", req_o); end
        addr_i = 5'd9; #1;
        n_cmp++; if (rdata_o !== 32'd20) begin n_fail++; $display("FAIL tmr_count: got %0d want 20", rdata_o); end
        addr_i = 5'd13;
        tick();
        @(negedge clk);
        n_cmp++; if (rdata_o[10+HW_INT] !== 1'b1) begin n_fail++; $display("FAIL tmr_ip: got %0b want 1", rdata_o[10+HW_INT]); end
        n_cmp++; if (req_o !== 1'b1) begin n_fail++; $display("FAIL tmr_req: got %0b want 1", req_o); end
        tick();
        we_i = 1'b1; addr_i = 5'd11; wdata_i = 32'd100;
        tick();
        we_i = 1'b0; addr_i = 5'd13;
        @(negedge clk);
        n_cmp++; if (rdata_o[10+HW_INT] !== 1'b0) begin n_fail++; $display("FAIL tmr_clear: got %0b want 0", rdata_o[10+HW_INT]); end
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
    endtask

    task automatic test_write_conflict();
        exc_code_i = 5'd5; we_i = 1'b1; addr_i = 5'd9; wdata_i = 32'hDEAD_0000;
        @(negedge clk);
        n_cmp++; if (req_o !== 1'b1) begin n_fail++; $display("FAIL wc_req: got %0b want 1", req_o); end
        tick();
        exc_code_i = 5'd0; we_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (rdata_o !== m_count) begin n_fail++; $display("FAIL wc_count_dropped: got %h want %h", rdata_o, m_count); end
        tick();
        we_i = 1'b1; addr_i = 5'd12; wdata_i = 32'h0000_0401;
        tick();
        we_i = 1'b0; hw_int_i = 5'b00001;
        tick();
        eret_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL wc_eret_mask: got %0b want 0", req_o); end
        tick();
        eret_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_o !== 1'b1) begin n_fail++; $display("FAIL wc_int_after_eret: got %0b want 1", req_o); end
        tick();
        hw_int_i = '0;
    endtask

    task automatic test_midop_reset();
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0; pc_i = 32'h3010; exc_code_i = 5'd12; bd_i = 1'b0;
        tick();
        exc_code_i = 5'd0; addr_i = 5'd14;
        @(negedge clk);
        n_cmp++; if (rdata_o !== 32'h3010) begin n_fail++; $display("FAIL mr_pre_epc: got %h want 3010", rdata_o); end
        #1 reset = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (epc_o !== 32'd0) begin n_fail++; $display("FAIL mr_epc: got %h want 0", epc_o); end
        n_cmp++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL mr_req: got %0b want 0", req_o); end
        for (int a = 9; a <= 15; a++) begin
            addr_i = 5'(a); #1;
            n_cmp++; if (rdata_o !== ((a == 15) ? PRID : 32'd0)) begin n_fail++; $display("FAIL mr_reg%0d: got %h want %h", a, rdata_o, (a == 15) ? PRID : 32'd0); end
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [4:0] ra;
        for (int i = 0; i < 400; i++) begin
            pc_i       = $urandom;
            bd_i       = 1'($urandom_range(0, 1));
            exc_code_i = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            if ($urandom_range(0, 15) == 0) hw_int_i = 5'($urandom);
            eret_i     = ($urandom_range(0, 9) == 0);
            we_i       = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 6))
                0: ra = 5'd9;
                1: ra = 5'd11;
                2: ra = 5'd12;
                3: ra = 5'd13;
                4: ra = 5'd14;
                5: ra = 5'd15;
                default: ra = 5'($urandom);
            endcase
            addr_i  = ra;
            wdata_i = $urandom;
            if (ra == 5'd11) wdata_i = m_count + 32'($urandom_range(2, 25));
            @(negedge clk);
            n_cmp++; if (req_o !== exp_req()) begin n_fail++; $display("FAIL rnd_req[%0d]: got %0b want %0b", i, req_o, exp_req()); end
            n_cmp++; if (epc_o !== m_epc) begin n_fail++; $display("FAIL rnd_epc[%0d]: got %h want %h", i, epc_o, m_epc); end
            n_cmp++; if (rdata_o !== exp_rdata(ra)) begin n_fail++; $display("FAIL rnd_rdata[%0d] addr %0d: got %h want %h", i, ra, rdata_o, exp_rdata(ra)); end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_overflow();
        test_delay_slot();
        test_priority();
        test_timer();
        test_write_conflict();
        test_midop_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
